video_timing_pattern_gen: RTL

- Parametrised successor to the fixed 1080p60 video generator feeding the HDMI transmitter's parallel RGB bus.
- Produces HS/VS/DE timing for any raster set by parameters; defaults are 1080p60 (148.5 MHz pixel clock from the HDMI PLL).
- Adds four run-time selectable test patterns, a programmable solid colour, frame-aligned enable/disable and a frame-start strobe.
- Instantiated on the pixel-clock domain; mode inputs come from the Nios II PIO (already synchronised to `clk`).

---
 rtl/video_timing_pattern_gen.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/video_timing_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_pattern_gen
// Brief    : Parametrised raster timing generator (HS/VS/DE) with four
//            selectable test patterns, frame-aligned start/stop and a
//            frame-start strobe. Drives the HDMI transmitter RGB bus.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module video_timing_pattern_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int COLOR_W  = 8,
    parameter int CHK_LOG2 = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           pattern_sel,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    output logic                 hs,
    output logic                 vs,
    output logic                 de,
    output logic [3*COLOR_W-1:0] rgb,
    output logic [15:0]          pixel_x,
    output logic [15:0]          pixel_y,
    output logic                 frame_start,
    output logic                 running
);

    // Raster geometry expressed in counter width so comparisons stay 16-bit.
    localparam logic [15:0] c_H_ACT      = 16'(H_ACTIVE);
    localparam logic [15:0] c_H_LAST     = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [15:0] c_HS_BEGIN   = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] c_HS_END     = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] c_V_ACT      = 16'(V_ACTIVE);
    localparam logic [15:0] c_V_LAST     = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [15:0] c_VS_BEGIN   = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] c_VS_END     = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] c_BAR_LAST   = 16'(H_ACTIVE / 8 - 1);
    localparam logic        c_HS_ON      = (HS_POL != 0);
    localparam logic        c_VS_ON      = (VS_POL != 0);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [15:0]          r_h_cnt;
    logic [15:0]          r_v_cnt;
    logic [15:0]          r_bar_cnt;
    logic [2:0]           r_bar_idx;
    logic [1:0]           r_sel;
    logic [3*COLOR_W-1:0] r_solid;

    logic                 w_run;
    logic                 w_h_last;
    logic                 w_v_last;
    logic                 w_frame_end;
    logic                 w_origin;
    logic                 w_latch;
    logic                 w_active;
    logic                 w_hs_on;
    logic                 w_vs_on;
    logic [1:0]           w_sel;
    logic [3*COLOR_W-1:0] w_solid;
    logic [3*COLOR_W-1:0] w_pix;

    assign w_run       = (r_state == ST_RUN);
    assign w_h_last    = (r_h_cnt == c_H_LAST);
    assign w_v_last    = (r_v_cnt == c_V_LAST);
    assign w_frame_end = w_h_last && w_v_last;
    assign w_origin    = w_run && (r_h_cnt == 16'd0) && (r_v_cnt == 16'd0);
    assign w_active    = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
    assign w_hs_on     = (r_h_cnt >= c_HS_BEGIN) && (r_h_cnt < c_HS_END);
    assign w_vs_on     = (r_v_cnt >= c_VS_BEGIN) && (r_v_cnt < c_VS_END);

    // Mode inputs are captured when leaving IDLE and again at pixel (0,0).
    // Pixel (0,0) itself uses the live inputs so the new frame is uniform.
    assign w_latch     = w_origin || ((r_state == ST_IDLE) && enable);
    assign w_sel       = w_origin ? pattern_sel : r_sel;
    assign w_solid     = w_origin ? solid_rgb   : r_solid;

    assign running     = w_run;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: start on enable, stop only once a whole frame has finished.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_frame_end && !enable) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Raster position counters; parked at (0,0) whenever not running.
    always_ff @(posedge clk) begin
        if (reset || !w_run) begin
            r_h_cnt <= 16'd0;
            r_v_cnt <= 16'd0;
        end else if (w_h_last) begin
            r_h_cnt <= 16'd0;
            r_v_cnt <= w_v_last ? 16'd0 : r_v_cnt + 16'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 16'd1;
        end
    end

    // Colour-bar index tracks h_cnt / (H_ACTIVE/8) without a divider.
    always_ff @(posedge clk) begin
        if (reset || !w_run || w_h_last) begin
            r_bar_cnt <= 16'd0;
            r_bar_idx <= 3'd0;
        end else if (r_h_cnt < c_H_ACT) begin
            if (r_bar_cnt == c_BAR_LAST) begin
                r_bar_cnt <= 16'd0;
                r_bar_idx <= r_bar_idx + 3'd1;
            end else begin
                r_bar_cnt <= r_bar_cnt + 16'd1;
            end
        end
    end

    // Shadow copies of the mode inputs, stable for a whole frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel   <= 2'd0;
            r_solid <= '0;
        end else if (w_latch) begin
            r_sel   <= pattern_sel;
            r_solid <= solid_rgb;
        end
    end

    // Pattern pixel for the current counter position.
    // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0].
    always_comb begin
        w_pix = '0;
        case (w_sel)
            2'd0: w_pix = w_solid;
            2'd1: w_pix = {{COLOR_W{~r_bar_idx[1]}},
                           {COLOR_W{~r_bar_idx[2]}},
                           {COLOR_W{~r_bar_idx[0]}}};
            2'd2: w_pix = {3{r_h_cnt[COLOR_W-1:0]}};
            default: w_pix = (r_h_cnt[CHK_LOG2] ^ r_v_cnt[CHK_LOG2]) ? '1 : '0;
        endcase
    end

    // Output register stage: one cycle behind the counters, all aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs          <= ~c_HS_ON;
            vs          <= ~c_VS_ON;
            de          <= 1'b0;
            rgb         <= '0;
            pixel_x     <= 16'd0;
            pixel_y     <= 16'd0;
            frame_start <= 1'b0;
        end else if (w_run) begin
            hs          <= w_hs_on ? c_HS_ON : ~c_HS_ON;
            vs          <= w_vs_on ? c_VS_ON : ~c_VS_ON;
            de          <= w_active;
            rgb         <= w_active ? w_pix : '0;
            frame_start <= w_origin;
            if (w_active) begin
                pixel_x <= r_h_cnt;
                pixel_y <= r_v_cnt;
            end
        end else begin
            hs          <= ~c_HS_ON;
            vs          <= ~c_VS_ON;
            de          <= 1'b0;
            rgb         <= '0;
            frame_start <= 1'b0;
        end
    end

endmodule
`default_nettype wire
